md_unit: RTL and testbench

Multiply/divide unit for the EX stage of the pipelined MIPS core. It sits beside the ALU and owns the HI/LO registers. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and sequences multi-cycle operations with a fixed-latency counter. It exports `busy` so the hazard unit can stall any later MD instruction and any MFHI/MFLO.

---
 rtl/md_defs.sv | 22 ++
 rtl/md_unit.sv | 117 +++++++++++
 tb/tb_md_unit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/md_defs.sv
// rtl/md_defs.sv - shared encodings and default latencies for the MIPS multiply/divide unit
package md_defs;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  localparam int MUL_CYCLES = 5;
  localparam int DIV_CYCLES = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/md_unit.sv
// rtl/md_unit.sv - EX-stage multiply/divide unit owning HI/LO with a fixed-latency busy sequence
module md_unit
  import md_defs::*;
#(
  parameter int MUL_CYCLES = md_defs::MUL_CYCLES,
  parameter int DIV_CYCLES = md_defs::DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic        cancel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  state_e          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [31:0]     res_hi, res_lo;
  logic            res_skip;
  logic            load, commit;
  md_op_e          op;
  logic            accept, is_mul, is_div;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] dvd_s, dvs_s, quo_s, rem_s;
  logic [31:0]        dvs_u, quo_u, rem_u;
  logic               dz, ovf;

  assign op     = md_op_e'(md_op);
  assign busy   = (state == RUN);
  assign is_mul = (op == MD_MULT) || (op == MD_MULTU);
  assign is_div = (op == MD_DIV) || (op == MD_DIVU);
  assign accept = start & ~cancel & ~busy & (op != MD_NONE);

  // Divisors are forced to 1 for the trapping cases so the dividers never see them;
  // the signed overflow case then yields quotient 0x80000000, remainder 0 for free.
  always_comb begin
    prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prod_u = {32'b0, A} * {32'b0, B};
    dz     = (B == 32'd0);
    ovf    = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    dvd_s  = $signed(A);
    dvs_s  = (dz || ovf) ? 32'sd1 : $signed(B);
    dvs_u  = dz ? 32'd1 : B;
    quo_s  = dvd_s / dvs_s;
    rem_s  = dvd_s % dvs_s;
    quo_u  = A / dvs_u;
    rem_u  = A % dvs_u;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (accept && (is_mul || is_div)) begin
          state_nxt = RUN;
          cnt_nxt   = is_mul ? MUL_LOAD : DIV_LOAD;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      res_hi   <= '0;
      res_lo   <= '0;
      res_skip <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load) begin
        case (op)
          MD_MULT:  {res_hi, res_lo} <= prod_s;
          MD_MULTU: {res_hi, res_lo} <= prod_u;
          MD_DIV:   begin res_lo <= quo_s; res_hi <= rem_s; end
          MD_DIVU:  begin res_lo <= quo_u; res_hi <= rem_u; end
          default:  ;
        endcase
        res_skip <= is_div & dz;
      end
      if (commit && !res_skip) begin
        hi <= res_hi;
        lo <= res_lo;
      end
      // MTHI/MTLO can only be accepted in IDLE, so they never collide with a commit.
      if (accept && op == MD_MTHI) hi <= A;
      if (accept && op == MD_MTLO) lo <= A;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - randomized scoreboard bench for md_unit against an arithmetic reference model
module tb_md_unit;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic        cancel = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic        busy;
  logic [31:0] hi, lo;

  md_unit dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .cancel(cancel),
    .A(A), .B(B), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          due;
    logic        bsy;
    logic [31:0] h;
    logic [31:0] l;
  } exp_t;
  exp_t sbq[$];

  logic [31:0] m_hi = '0, m_lo = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      if (e.due < cyc) chk("missed_slot", 32'(cyc), 32'(e.due));
      chk("busy", {31'b0, busy}, {31'b0, e.bsy});
      chk("hi", hi, e.h);
      chk("lo", lo, e.l);
    end
  end

  task automatic push(input int due, input logic bsy, input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    e.due = due; e.bsy = bsy; e.h = h; e.l = l;
    sbq.push_back(e);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at #1 after a rising edge; the operation is presented for the next edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit canc, input bit intrude);
    int          e0, n;
    logic [31:0] nh, nl;
    longint      sa, sb, p;
    logic [63:0] pu;
    start = 1'b1; md_op = op; A = a; B = b; cancel = canc;
    e0 = cyc + 1;
    nh = m_hi; nl = m_lo; n = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!canc) begin
      case (op)
        3'd1: begin p = sa * sb; {nh, nl} = p; n = MUL_N; end
        3'd2: begin pu = {32'b0, a} * {32'b0, b}; {nh, nl} = pu; n = MUL_N; end
        3'd3: begin
          if (b != 0) begin p = sa / sb; nl = p[31:0]; p = sa % sb; nh = p[31:0]; end
          n = DIV_N;
        end
        3'd4: begin
          if (b != 0) begin nl = a / b; nh = a % b; end
          n = DIV_N;
        end
        3'd5: nh = a;
        3'd6: nl = a;
        default: ;
      endcase
    end
    for (int d = 0; d < n; d++) push(e0 + d, 1'b1, m_hi, m_lo);
    push(e0 + n, 1'b0, nh, nl);
    m_hi = nh; m_lo = nl;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0; md_op = 3'd0;
    if (intrude && n > 0) begin
      @(posedge clk); #1;
      start = 1'b1; md_op = 3'd1; A = $urandom; B = $urandom;
      @(posedge clk); #1;
      start = 1'b0; md_op = 3'd0;
    end
    wait_until(e0 + n);
  endtask

  task automatic reset_mid_div();
    int e0;
    start = 1'b1; md_op = 3'd3; A = 32'd100; B = 32'd7; cancel = 1'b0;
    e0 = cyc + 1;
    for (int d = 0; d < 3; d++) push(e0 + d, 1'b1, m_hi, m_lo);
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
    wait_until(e0 + 3);
    reset = 1'b0;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    push(e0 + DIV_N, 1'b0, 32'd0, 32'd0);
    push(e0 + DIV_N + 1, 1'b0, 32'd0, 32'd0);
    wait_until(e0 + DIV_N + 1);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] rb;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    issue(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    issue(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    issue(3'd4, 32'd7, 32'd2, 1'b0, 1'b0);
    issue(3'd5, 32'h11, 32'd0, 1'b0, 1'b0);
    issue(3'd6, 32'h22, 32'd0, 1'b0, 1'b0);
    issue(3'd3, 32'd5, 32'd0, 1'b0, 1'b0);
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    issue(3'd1, 32'd9, 32'd9, 1'b1, 1'b0);
    issue(3'd1, 32'h1234_5678, 32'h0000_0100, 1'b0, 1'b1);
    issue(3'd6, 32'h5, 32'd0, 1'b0, 1'b0);
    reset_mid_div();

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 6));
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      issue(rop, $urandom, rb, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
    end

    repeat (3) @(posedge clk);
    #1;
    if (sbq.size() != 0) chk("scoreboard_drain", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
